cam_alloc: RTL and testbench

CAM_ALLOC -- requirements
Module: cam_alloc

---
 rtl/cam_pkg.sv | 19 +
 rtl/cam_alloc_pick.sv | 28 ++
 rtl/cam_alloc.sv | 171 +++++++++++++++++
 tb/tb_cam_alloc.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types for the CAM slot allocator.
// Response status codes and allocator FSM states.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_NEW   = 2'b00,
    ST_HIT   = 2'b01,
    ST_FULL  = 2'b10,
    ST_EVICT = 2'b11
  } cam_status_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOOKUP = 2'b01,
    ALLOC  = 2'b10,
    RESP   = 2'b11
  } cam_state_e;

endpackage

// File: rtl/cam_alloc_pick.sv
// First-free slot picker: lowest-index clear bit of used_i.
// Ports: used_i (occupancy), pos_o (onehot), idx_o, any_free_o.
module cam_alloc_pick #(
  parameter int CNT_N = 32,
  localparam int ADDR_W = $clog2(CNT_N)
) (
  input  logic [CNT_N-1:0]  used_i,
  output logic [CNT_N-1:0]  pos_o,
  output logic [ADDR_W-1:0] idx_o,
  output logic              any_free_o
);

  // Scan downwards so the lowest free index is the last to win.
  always_comb begin
    pos_o      = '0;
    idx_o      = '0;
    any_free_o = 1'b0;
    for (int i = CNT_N - 1; i >= 0; i--) begin
      if (!used_i[i]) begin
        pos_o      = '0;
        pos_o[i]   = 1'b1;
        idx_o      = ADDR_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_alloc.sv
// CAM slot allocator: lookup key, hit/allocate/full response.
// Ports: clk, nreset (sync, active-low); req_* insert handshake;
// rsp_* response handshake; free_* release; cam_rd_*/cam_match_i/
// cam_addr_i lookup; cam_alloc_* CAM write; full_o, used_cnt_o.
// Macro CAM_ALLOC_EVICT_EN: round-robin eviction when full.
module cam_alloc
  import cam_pkg::*;
#(
  parameter int CNT_N = 32,
  parameter int KEY_W = 8,
  localparam int ADDR_W = $clog2(CNT_N)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [KEY_W-1:0]  req_key_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [1:0]        rsp_status_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  input  logic              free_i,
  input  logic [ADDR_W-1:0] free_addr_i,
  output logic              cam_rd_o,
  output logic [KEY_W-1:0]  cam_rd_key_o,
  input  logic              cam_match_i,
  input  logic [ADDR_W-1:0] cam_addr_i,
  output logic              cam_alloc_o,
  output logic [CNT_N-1:0]  cam_alloc_pos_o,
  output logic [KEY_W-1:0]  cam_alloc_key_o,
  output logic              full_o,
  output logic [ADDR_W:0]   used_cnt_o
);

  cam_state_e        state_q, state_d;
  cam_status_e       status_q, status_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_N-1:0]  pos_q, pos_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [CNT_N-1:0]  used_q, used_d;
`ifdef CAM_ALLOC_EVICT_EN
  logic [ADDR_W-1:0] victim_q, victim_d;
`endif

  logic [CNT_N-1:0]  pick_pos;
  logic [ADDR_W-1:0] pick_idx;
  logic              pick_any;
  logic              hit;

  cam_alloc_pick #(
    .CNT_N (CNT_N)
  ) u_pick (
    .used_i     (used_q),
    .pos_o      (pick_pos),
    .idx_o      (pick_idx),
    .any_free_o (pick_any)
  );

  // A CAM line whose slot is unused, or freed this very cycle,
  // is stale and must not count as a hit.
  assign hit = cam_match_i
             & used_q[cam_addr_i]
             & ~(free_i & (free_addr_i == cam_addr_i));

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    addr_d   = addr_q;
    pos_d    = pos_q;
    key_d    = key_q;
`ifdef CAM_ALLOC_EVICT_EN
    victim_d = victim_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          key_d   = req_key_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          status_d = ST_HIT;
          addr_d   = cam_addr_i;
          state_d  = RESP;
        end else if (pick_any) begin
          status_d = ST_NEW;
          addr_d   = pick_idx;
          pos_d    = pick_pos;
          state_d  = ALLOC;
        end else begin
`ifdef CAM_ALLOC_EVICT_EN
          status_d        = ST_EVICT;
          addr_d          = victim_q;
          pos_d           = '0;
          pos_d[victim_q] = 1'b1;
          state_d         = ALLOC;
`else
          status_d = ST_FULL;
          addr_d   = '0;
          state_d  = RESP;
`endif
        end
      end
      ALLOC: begin
        state_d = RESP;
`ifdef CAM_ALLOC_EVICT_EN
        if (status_q == ST_EVICT) begin
          if (victim_q == ADDR_W'(CNT_N - 1))
            victim_d = '0;
          else
            victim_d = victim_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Set after clear: a same-cycle free of the target loses.
  always_comb begin
    used_d = used_q;
    if (free_i) used_d[free_addr_i] = 1'b0;
    if (state_q == ALLOC) used_d = used_d | pos_q;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= IDLE;
      status_q <= ST_NEW;
      addr_q   <= '0;
      pos_q    <= '0;
      key_q    <= '0;
      used_q   <= '0;
`ifdef CAM_ALLOC_EVICT_EN
      victim_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      pos_q    <= pos_d;
      key_q    <= key_d;
      used_q   <= used_d;
`ifdef CAM_ALLOC_EVICT_EN
      victim_q <= victim_d;
`endif
    end
  end

  always_comb begin
    used_cnt_o = '0;
    for (int i = 0; i < CNT_N; i++)
      used_cnt_o = used_cnt_o + (ADDR_W + 1)'(used_q[i]);
  end

  assign full_o          = &used_q;
  assign req_ready_o     = (state_q == IDLE);
  assign cam_rd_o        = (state_q == LOOKUP);
  assign cam_rd_key_o    = key_q;
  assign cam_alloc_o     = (state_q == ALLOC);
  assign cam_alloc_pos_o = cam_alloc_o ? pos_q : '0;
  assign cam_alloc_key_o = key_q;
  assign rsp_valid_o     = (state_q == RESP);
  assign rsp_status_o    = status_q;
  assign rsp_addr_o      = addr_q;

endmodule

// File: tb/tb_cam_alloc.sv
// Directed bench for cam_alloc (CNT_N=4) with a small CAM model.
// Honours CAM_ALLOC_EVICT_EN for the full-table expectations.
module tb_cam_alloc;

  localparam int N  = 4;
  localparam int KW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          nreset;
  logic          req_valid;
  logic          req_ready;
  logic [KW-1:0] req_key;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_status;
  logic [AW-1:0] rsp_addr;
  logic          free_v;
  logic [AW-1:0] free_addr;
  logic          cam_rd;
  logic [KW-1:0] cam_rd_key;
  logic          cam_match;
  logic [AW-1:0] cam_addr;
  logic          cam_wr;
  logic [N-1:0]  cam_pos;
  logic [KW-1:0] cam_wkey;
  logic          full;
  logic [AW:0]   used_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cam_alloc #(.CNT_N(N), .KEY_W(KW)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_key_i       (req_key),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_status_o    (rsp_status),
    .rsp_addr_o      (rsp_addr),
    .free_i          (free_v),
    .free_addr_i     (free_addr),
    .cam_rd_o        (cam_rd),
    .cam_rd_key_o    (cam_rd_key),
    .cam_match_i     (cam_match),
    .cam_addr_i      (cam_addr),
    .cam_alloc_o     (cam_wr),
    .cam_alloc_pos_o (cam_pos),
    .cam_alloc_key_o (cam_wkey),
    .full_o          (full),
    .used_cnt_o      (used_cnt)
  );

  // CAM model: lines are never invalidated by free, so stale
  // matches reach the DUT exactly as a real CAM would present them.
  logic [KW-1:0] cam_key [N];
  logic          cam_vld [N];
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic [N-1:0]  last_pos = '0;
  logic [KW-1:0] last_key = '0;

  initial for (int i = 0; i < N; i++) begin
    cam_key[i] = '0;
    cam_vld[i] = 1'b0;
  end

  always @(posedge clk) begin
    if (cam_rd) rd_cnt++;
    if (cam_wr) begin
      wr_cnt++;
      last_pos = cam_pos;
      last_key = cam_wkey;
      for (int i = 0; i < N; i++)
        if (cam_pos[i]) begin
          cam_key[i] = cam_wkey;
          cam_vld[i] = 1'b1;
        end
    end
  end

  always_comb begin
    cam_match = 1'b0;
    cam_addr  = '0;
    for (int i = N - 1; i >= 0; i--)
      if (cam_rd && cam_vld[i] && cam_key[i] == cam_rd_key) begin
        cam_match = 1'b1;
        cam_addr  = AW'(i);
      end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Insert one key; lat is the expected accept-to-rsp_valid cycle
  // count; hold keeps rsp_ready low that many cycles first.
  task automatic do_insert(input string tag, input logic [KW-1:0] key,
                           input logic [1:0] st, input logic [AW-1:0] ad,
                           input int lat, input int hold);
    int n;
    int wr0;
    int rd0;
    logic [N-1:0] onehot;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    check_eq({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_key   = key;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
    end while (!rsp_valid && n < 20);
    check_eq({tag, ".lat"}, 32'(n), 32'(lat));
    for (int i = 0; i < hold; i++) begin
      check_eq($sformatf("%s.hv%0d", tag, i), 32'(rsp_valid), 32'd1);
      check_eq($sformatf("%s.hs%0d", tag, i), 32'(rsp_status), 32'(st));
      check_eq($sformatf("%s.ha%0d", tag, i), 32'(rsp_addr), 32'(ad));
      check_eq($sformatf("%s.hr%0d", tag, i), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    check_eq({tag, ".status"}, 32'(rsp_status), 32'(st));
    check_eq({tag, ".addr"}, 32'(rsp_addr), 32'(ad));
    check_eq({tag, ".rdcnt"}, 32'(rd_cnt - rd0), 32'd1);
    check_eq({tag, ".wrcnt"}, 32'(wr_cnt - wr0), (lat == 3) ? 32'd1 : 32'd0);
    if (lat == 3) begin
      onehot = '0;
      onehot[ad] = 1'b1;
      check_eq({tag, ".pos"}, 32'(last_pos), 32'(onehot));
      check_eq({tag, ".wkey"}, 32'(last_key), 32'(key));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, ".vdone"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_free(input logic [AW-1:0] a);
    free_v    = 1'b1;
    free_addr = a;
    @(negedge clk);
    free_v    = 1'b0;
  endtask

  initial begin
    nreset    = 1'b0;
    req_valid = 1'b0;
    req_key   = '0;
    rsp_ready = 1'b0;
    free_v    = 1'b0;
    free_addr = '0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check_eq("rst.ready", 32'(req_ready), 32'd1);
    check_eq("rst.rspv", 32'(rsp_valid), 32'd0);
    check_eq("rst.cnt", 32'(used_cnt), 32'd0);
    check_eq("rst.full", 32'(full), 32'd0);
    check_eq("rst.rd", 32'(cam_rd), 32'd0);
    check_eq("rst.wr", 32'(cam_wr), 32'd0);

    do_insert("new11", 8'h11, 2'b00, 2'd0, 3, 0);
    do_insert("hit11", 8'h11, 2'b01, 2'd0, 2, 0);
    do_insert("new22", 8'h22, 2'b00, 2'd1, 3, 0);
    do_insert("new33", 8'h33, 2'b00, 2'd2, 3, 0);
    do_insert("new44", 8'h44, 2'b00, 2'd3, 3, 0);
    check_eq("full.flag", 32'(full), 32'd1);
    check_eq("full.cnt", 32'(used_cnt), 32'd4);
`ifdef CAM_ALLOC_EVICT_EN
    do_insert("ev55", 8'h55, 2'b11, 2'd0, 3, 0);
    do_insert("ev66", 8'h66, 2'b11, 2'd1, 3, 0);
`else
    do_insert("full55", 8'h55, 2'b10, 2'd0, 2, 0);
    do_insert("full66", 8'h66, 2'b10, 2'd0, 2, 0);
`endif
    check_eq("full.cnt2", 32'(used_cnt), 32'd4);

    do_free(2'd1);
    check_eq("free1.cnt", 32'(used_cnt), 32'd3);
    check_eq("free1.full", 32'(full), 32'd0);
    do_free(2'd1);
    check_eq("free1x.cnt", 32'(used_cnt), 32'd3);
    do_insert("stale22", 8'h22, 2'b00, 2'd1, 3, 0);
    check_eq("stale.cnt", 32'(used_cnt), 32'd4);

    do_insert("stall33", 8'h33, 2'b01, 2'd2, 2, 5);

    do_free(2'd3);
    check_eq("free3.cnt", 32'(used_cnt), 32'd3);
    req_valid = 1'b1;
    req_key   = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("rstal.wr", 32'(cam_wr), 32'd1);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rstal.v%0d", i), 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    check_eq("rstal.cnt", 32'(used_cnt), 32'd0);
    check_eq("rstal.ready", 32'(req_ready), 32'd1);
    do_insert("post11", 8'h11, 2'b00, 2'd0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
